fifo_rd_stream_adapter: RTL and testbench

- Read-side stage that sits directly downstream of `asynchronous_fifo`, in the `rd_clk` domain.
- Converts the FIFO's registered read port (`rd_en`/`empty`/`data_out`, one-cycle read latency) into a first-word-fall-through valid/ready stream.
- Holds data in a 2-entry output buffer, so the consumer can stall without losing a word that is already in flight.
- Sustains one word per cycle while the consumer is ready, and counts delivered words.

---
 rtl/fifo_rd_stream_adapter.sv | 102 ++++++++++
 tb/tb_fifo_rd_stream_adapter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter for asynchronous_fifo: turns the registered rd_en/empty/data_out port
// into a first-word-fall-through valid/ready stream with a 2-entry buffer and a word counter.
module fifo_rd_stream_adapter #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  words_out
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_cnt_e;

  buf_cnt_e              buf_cnt, buf_cnt_nxt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] h, h_nxt;
  logic [DATA_WIDTH-1:0] s, s_nxt;
  logic                  pop;
  logic                  land;
  logic [2:0]            occ;

  assign m_valid = (buf_cnt != EMPTY);
  assign m_data  = h;
  assign pop     = m_valid && m_ready;
  assign land    = inflight;

  // Words owned after this edge if no new read is issued; a read is allowed only while
  // that leaves room, so held + in-flight words never exceed the two buffer entries.
  assign occ        = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = !rst && !flush && !fifo_empty && (occ <= 3'd1);

  // NOTE: every output of this block gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    buf_cnt_nxt = buf_cnt;
    h_nxt       = h;
    s_nxt       = s;
    if (flush) begin
      buf_cnt_nxt = EMPTY;
    end else begin
      case (buf_cnt)
        EMPTY: begin
          if (land) begin
            buf_cnt_nxt = ONE;
            h_nxt       = fifo_rd_data;
          end
        end
        ONE: begin
          case ({land, pop})
            2'b10: begin
              buf_cnt_nxt = TWO;
              s_nxt       = fifo_rd_data;
            end
            2'b11:   h_nxt       = fifo_rd_data;
            2'b01:   buf_cnt_nxt = EMPTY;
            default: buf_cnt_nxt = ONE;
          endcase
        end
        TWO: begin
          // A landing word with no pop cannot arrive here; the issue rule prevents it.
          if (pop) begin
            h_nxt = s;
            if (land) s_nxt = fifo_rd_data;
            else      buf_cnt_nxt = ONE;
          end
        end
        default: buf_cnt_nxt = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_cnt   <= EMPTY;
      inflight  <= 1'b0;
      // NOTE: the two data entries are cleared on reset so m_data reads 0 out of reset.
      h         <= '0;
      s         <= '0;
      words_out <= '0;
    end else begin
      buf_cnt  <= buf_cnt_nxt;
      inflight <= fifo_rd_en;
      h        <= h_nxt;
      s        <= s_nxt;
      if (pop && !flush) words_out <= words_out + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Self-checking bench for fifo_rd_stream_adapter: a queue-based FIFO and an outstanding-word
// scoreboard predict valid, data, rd_en and the delivered-word count every cycle.
module tb_fifo_rd_stream_adapter;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst, flush, fifo_empty, m_ready;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_en, m_valid;
  logic [DW-1:0] m_data;
  logic [15:0]   words_out;
  logic          fifo_rd_en_w, m_valid_w;
  logic [DW-1:0] m_data_w;
  logic [3:0]    words_out_w;

  always #5 clk = ~clk;

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .words_out(words_out)
  );

  fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w (
    .clk(clk), .rst(rst), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en_w), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid_w), .m_ready(m_ready), .m_data(m_data_w), .words_out(words_out_w)
  );

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } word_t;

  logic [DW-1:0] fq[$];      // words still inside the FIFO
  word_t         oq[$];      // words read from the FIFO and not yet delivered
  logic [DW-1:0] dlog[$];    // delivered words
  logic [DW-1:0] ref_w[$];
  int            cyc, n_checks, n_errors, rd_pulses;
  int unsigned   model_cnt;
  bit            sparse, sparse_phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle; entered and left just after a falling edge.
  task automatic cycle();
    bit    exp_valid, exp_pop, exp_rd, act_rd;
    word_t w;
    fifo_empty = (fq.size() == 0) || (sparse && sparse_phase);
    #1;
    // A word read in cycle t lands in t+1 and is presented from t+2.
    exp_valid = (oq.size() > 0) && (oq[0].t + 2 <= cyc);
    exp_pop   = exp_valid && m_ready && !rst && !flush;
    exp_rd    = !rst && !flush && !fifo_empty && (oq.size() - int'(exp_pop) <= 1);
    check("m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
    check("m_valid_w", {31'd0, m_valid_w}, {31'd0, exp_valid});
    if (exp_valid) begin
      check("m_data", {24'd0, m_data}, {24'd0, oq[0].d});
      check("m_data_w", {24'd0, m_data_w}, {24'd0, oq[0].d});
    end
    check("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, exp_rd});
    check("fifo_rd_en_w", {31'd0, fifo_rd_en_w}, {31'd0, exp_rd});
    check("words_out", {16'd0, words_out}, model_cnt & 32'hFFFF);
    check("words_out4", {28'd0, words_out_w}, model_cnt & 32'hF);
    act_rd = fifo_rd_en;
    if (act_rd) rd_pulses++;
    @(posedge clk);
    if (rst) begin
      oq.delete();
      model_cnt = 0;
    end else if (flush) begin
      oq.delete();
    end else if (exp_pop) begin
      dlog.push_back(oq[0].d);
      void'(oq.pop_front());
      model_cnt++;
    end
    #1;
    if (act_rd && fq.size() > 0) begin
      w.d = fq.pop_front();
      w.t = cyc;
      if (!rst && !flush) oq.push_back(w);
      fifo_rd_data = w.d;
    end
    cyc++;
    sparse_phase = !sparse_phase;
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input string tag, input int target, input int budget);
    int k = 0;
    while (dlog.size() < target && k < budget) begin
      cycle();
      k++;
    end
    check(tag, dlog.size(), target);
  endtask

  task automatic push_random(input int n);
    logic [DW-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = DW'($urandom_range(0, 255));
      fq.push_back(v);
      ref_w.push_back(v);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run(1);
    rst = 1'b0;
  endtask

  logic [DW-1:0] nxt;
  logic [15:0]   saved;

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_rd_data = '0;
    sparse = 1'b0; sparse_phase = 1'b0;
    cyc = 0; n_checks = 0; n_errors = 0; rd_pulses = 0; model_cnt = 0;

    // Reset values
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {24'd0, m_data}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_words_out", {16'd0, words_out}, 32'd0);
    check("rst_words_out4", {28'd0, words_out_w}, 32'd0);

    // Reset mid-stream, then A1 B2 C3 after release
    rst = 1'b0; m_ready = 1'b1;
    push_random(5);
    run(4);
    rst = 1'b1;
    fq.delete();
    fq.push_back(8'hA1); fq.push_back(8'hB2); fq.push_back(8'hC3);
    run(3);
    rst = 1'b0;
    dlog.delete();
    run(2);
    check("rel_valid_c2", {31'd0, m_valid}, 32'd1);
    run(3);
    check("rel_cnt", dlog.size(), 3);
    if (dlog.size() == 3) begin
      check("rel_w0", {24'd0, dlog[0]}, 32'hA1);
      check("rel_w1", {24'd0, dlog[1]}, 32'hB2);
      check("rel_w2", {24'd0, dlog[2]}, 32'hC3);
    end
    check("rel_words_out", {16'd0, words_out}, 32'd3);

    // Stall then resume
    m_ready = 1'b0;
    do_reset();
    ref_w.delete();
    push_random(10);
    rd_pulses = 0;
    dlog.delete();
    run(8);
    check("stall_reads", rd_pulses, 2);
    check("stall_valid", {31'd0, m_valid}, 32'd1);
    check("stall_data", {24'd0, m_data}, {24'd0, ref_w[0]});
    m_ready = 1'b1;
    run(10);
    check("resume_rate", dlog.size(), 10);
    for (int i = 0; i < 10 && i < dlog.size(); i++)
      check("resume_order", {24'd0, dlog[i]}, {24'd0, ref_w[i]});
    run(3);

    // Random m_ready, 200 words
    do_reset();
    push_random(200);
    dlog.delete();
    begin
      int k = 0;
      while (dlog.size() < 200 && k < 2000) begin
        m_ready = 1'($urandom_range(0, 1));
        cycle();
        k++;
      end
    end
    check("rand_delivered", dlog.size(), 200);
    check("rand_words_out", {16'd0, words_out}, 32'd200);
    check("rand_words_out4", {28'd0, words_out_w}, 32'd8);

    // Flush while stalled with two words held
    m_ready = 1'b0;
    push_random(6);
    run(4);
    saved = words_out;
    nxt   = fq[0];
    flush = 1'b1;
    run(1);
    flush = 1'b0;
    check("flush_valid", {31'd0, m_valid}, 32'd0);
    check("flush_cnt_kept", {16'd0, words_out}, {16'd0, saved});
    m_ready = 1'b1;
    dlog.delete();
    drain("flush_next_arrives", 1, 10);
    if (dlog.size() > 0) check("flush_next_word", {24'd0, dlog[0]}, {24'd0, nxt});

    // Flush while streaming with m_ready high: no handshake counted
    push_random(8);
    run(3);
    saved = words_out;
    nxt   = fq[0];
    flush = 1'b1;
    run(1);
    flush = 1'b0;
    check("flush2_valid", {31'd0, m_valid}, 32'd0);
    check("flush2_cnt_kept", {16'd0, words_out}, {16'd0, saved});
    dlog.delete();
    drain("flush2_next_arrives", 1, 10);
    if (dlog.size() > 0) check("flush2_next_word", {24'd0, dlog[0]}, {24'd0, nxt});
    run(16);

    // Counter wrap on the 4-bit instance
    do_reset();
    fq.delete();
    push_random(17);
    dlog.delete();
    begin
      int k = 0;
      while (dlog.size() < 17 && k < 100) begin
        cycle();
        k++;
        if (dlog.size() == 15) check("wrap_15", {28'd0, words_out_w}, 32'd15);
        if (dlog.size() == 16) check("wrap_0", {28'd0, words_out_w}, 32'd0);
        if (dlog.size() == 17) check("wrap_1", {28'd0, words_out_w}, 32'd1);
      end
    end
    check("wrap_delivered", dlog.size(), 17);

    // Sparse FIFO: empty toggles every cycle
    do_reset();
    ref_w.delete();
    push_random(20);
    dlog.delete();
    sparse = 1'b1;
    drain("sparse_delivered", 20, 200);
    for (int i = 0; i < 20 && i < dlog.size(); i++)
      check("sparse_order", {24'd0, dlog[i]}, {24'd0, ref_w[i]});
    sparse = 1'b0;
    run(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
